// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and default timing for the button conditioner
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    localparam int DEF_NUM_BTN         = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HOLD_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;
    localparam bit DEF_REPEAT_EN       = 1'b1;
    localparam bit DEF_ACTIVE_HIGH     = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debouncer, press/hold/repeat sequencer
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = DEF_REPEAT_EN,
    parameter bit ACTIVE_HIGH     = DEF_ACTIVE_HIGH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_MAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int TM_W   = $clog2(TM_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_SAT    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYCLES - 1);
    localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REPEAT_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_SAT    = TM_W'(TM_MAX);

    logic            pin;
    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;
    logic            level_q;
    logic            accept;
    logic            acc_press;
    logic            acc_release;
    logic [TM_W-1:0] tm_cnt;
    btn_state_t      state_q;
    btn_state_t      state_d;
    logic            hold_set;
    logic            repeat_set;

    // Normalise polarity so everything downstream treats 1 as "pressed".
    assign pin = ACTIVE_HIGH ? raw : ~raw;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign accept      = (sync2 != level_q) && (db_cnt == DB_LAST);
    assign acc_press   = accept & ~level_q;
    assign acc_release = accept & level_q;

    // Debounce counter and accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt  <= '0;
            level_q <= 1'b0;
        end else begin
            if ((sync2 == level_q) || accept) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_SAT) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (accept) begin
                level_q <= ~level_q;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: release always wins over the hold transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_press) begin
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (acc_release) begin
                    state_d = IDLE;
                end else if (tm_cnt == HOLD_LAST) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (acc_release) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Event decode for the hold and auto-repeat pulses, suppressed on release.
    always_comb begin
        hold_set   = 1'b0;
        repeat_set = 1'b0;
        if (!acc_release) begin
            hold_set   = (state_q == PRESSED) && (tm_cnt == HOLD_LAST);
            repeat_set = REPEAT_EN && (state_q == HELD) && (tm_cnt == REP_LAST);
        end
    end

    // Shared hold/repeat timer: zero on the press cycle and after every emitted event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_cnt <= '0;
        end else if (acc_press || acc_release || hold_set || repeat_set || (state_q == IDLE)) begin
            tm_cnt <= '0;
        end else if (tm_cnt != TM_SAT) begin
            tm_cnt <= tm_cnt + 1'b1;
        end
    end

    // Registered event pulses, aligned with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= acc_press;
            release_pulse <= acc_release;
            hold_pulse    <= hold_set;
            repeat_pulse  <= repeat_set;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - bank of independent debounced button channels
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = DEF_REPEAT_EN,
    parameter bit ACTIVE_HIGH     = DEF_ACTIVE_HIGH
) (
    input  logic               SYSCLK,
    input  logic               RSTN,
    input  logic [NUM_BTN-1:0] BTN_IN,
    output logic [NUM_BTN-1:0] BTN_LEVEL,
    output logic [NUM_BTN-1:0] BTN_PRESS,
    output logic [NUM_BTN-1:0] BTN_RELEASE,
    output logic [NUM_BTN-1:0] BTN_HOLD,
    output logic [NUM_BTN-1:0] BTN_REPEAT
);

    // One self-contained channel per button bit.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .ACTIVE_HIGH     (ACTIVE_HIGH)
        ) u_chan (
            .clk           (SYSCLK),
            .rst_n         (RSTN),
            .raw           (BTN_IN[i]),
            .level         (BTN_LEVEL[i]),
            .press_pulse   (BTN_PRESS[i]),
            .release_pulse (BTN_RELEASE[i]),
            .hold_pulse    (BTN_HOLD[i]),
            .repeat_pulse  (BTN_REPEAT[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 3, number of independent button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable samples required to accept a change (10 ms at 100 MHz; minimum 1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 50000000, pressed duration before the long-press event (minimum 1).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat interval after the long-press event (minimum 1).
REQ-005 SHALL have parameter REPEAT_EN, default 1, enables auto-repeat pulses.
REQ-006 SHALL have parameter ACTIVE_HIGH, default 1; when 0, raw inputs are inverted before synchronisation.
REQ-007 SHALL have port SYSCLK  input  1  system clock; the single clock, rising-edge.
REQ-008 SHALL have port RSTN  input  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have port BTN_IN  input  NUM_BTN  raw, asynchronous, bouncing button pins.
REQ-010 SHALL have port BTN_LEVEL  output  NUM_BTN  debounced pressed state.
REQ-011 SHALL have port BTN_PRESS  output  NUM_BTN  one-cycle pulse on accepted press.
REQ-012 SHALL have port BTN_RELEASE  output  NUM_BTN  one-cycle pulse on accepted release.
REQ-013 SHALL have port BTN_HOLD  output  NUM_BTN  one-cycle pulse when a press reaches HOLD_CYCLES.
REQ-014 SHALL have port BTN_REPEAT  output  NUM_BTN  one-cycle auto-repeat pulse.

Function
REQ-015 Each channel SHALL pass its (polarity-corrected) input through a 2-flop synchroniser; all later logic uses only the synchronised bit.
REQ-016 Debounce counter SHALL clear whenever the synchronised bit equals BTN_LEVEL, and increment otherwise; it SHALL accept the change when DEBOUNCE_CYCLES consecutive differing samples are seen.
REQ-017 A clean input edge SHALL appear on BTN_LEVEL exactly 2+DEBOUNCE_CYCLES SYSCLK edges later; any pulse or glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no output change.
REQ-018 BTN_PRESS and BTN_RELEASE SHALL assert in the same cycle BTN_LEVEL rises and falls respectively, for exactly one cycle.
REQ-019 Per-channel FSM SHALL have states IDLE, PRESSED, HELD: IDLE->PRESSED on accepted press; PRESSED->HELD when hold counter reaches HOLD_CYCLES (BTN_HOLD pulse that cycle); PRESSED or HELD->IDLE on accepted release.
REQ-020 Hold counter SHALL start at zero on the BTN_PRESS cycle; BTN_HOLD SHALL assert HOLD_CYCLES cycles after BTN_PRESS.
REQ-021 In HELD with REPEAT_EN=1, BTN_REPEAT SHALL pulse every REPEAT_CYCLES cycles, first pulse REPEAT_CYCLES after BTN_HOLD; with REPEAT_EN=0, BTN_REPEAT SHALL stay 0.
REQ-022 Release SHALL take priority: on the accepted-release cycle no BTN_HOLD or BTN_REPEAT SHALL assert, and all channel counters SHALL clear.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each pulse in their own bit the same cycle.
REQ-024 Counter widths SHALL be $clog2(max count + 1); counters SHALL saturate, never wrap.

Reset
REQ-025 RSTN low SHALL immediately force all outputs, synchroniser flops, counters to 0 and every FSM to IDLE.
REQ-026 Reset asserted mid-press SHALL emit no BTN_RELEASE; after RSTN rises, a still-held button SHALL be re-accepted as a new press after the normal debounce latency.

Structure
REQ-027 Package button_pkg SHALL hold the FSM state enum (IDLE, PRESSED, HELD) and the default timing constants.
REQ-028 Per-channel logic SHALL live in sub-module button_channel, instantiated NUM_BTN times by a generate loop in button_conditioner.

Verification (NUM_BTN=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1)
REQ-029 BTN_IN[0] rises cleanly at cycle 100 -> BTN_LEVEL[0] and one-cycle BTN_PRESS[0] at cycle 106; release at 110 -> BTN_RELEASE[0] at 116, no BTN_HOLD.
REQ-030 BTN_IN[1] toggles every 2 cycles for 40 cycles, then stays low -> BTN_LEVEL[1], BTN_PRESS[1], BTN_RELEASE[1] remain 0 throughout.
REQ-031 BTN_IN[2] held high from cycle 200 -> BTN_PRESS[2] at 206, BTN_HOLD[2] at 226, BTN_REPEAT[2] at 234, 242, 250 until release; no repeat on the release cycle.
REQ-032 All three inputs rise the same cycle -> BTN_PRESS = 3'b111 for exactly one cycle, 6 cycles later.
REQ-033 RSTN pulsed low while BTN_IN[0] is held (state HELD) -> all outputs 0 at once, no BTN_RELEASE; after RSTN rises, BTN_PRESS[0] 6 cycles later.
REQ-034 ACTIVE_HIGH=0 build, BTN_IN[0] driven low -> BTN_PRESS[0] with identical 6-cycle latency.
